// File: rtl/cae_layer_sched.sv
// Layer scheduler for the 3-PE CAE datapath: walks one conv or FC layer per start,
// producing buffer addresses, datapath enables and a done/err status.
module cae_layer_sched #(
    parameter int OUT_CH        = 8,
    parameter int OUT_ROWS      = 4,
    parameter int FC_COLS       = 16,
    parameter int ADDR_WIDTH    = 8,
    parameter int FC_WCOL_WIDTH = 5,
    parameter int MEM_LAT       = 1,
    parameter int TIMEOUT       = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     layer_sel,
    input  logic                     abort,
    input  logic                     conv_comp,
    input  logic                     fc_line_done,
    input  logic                     fc_done,
    output logic                     rd_en,
    output logic [ADDR_WIDTH-1:0]    data_addr,
    output logic [ADDR_WIDTH-1:0]    weight_addr,
    output logic [ADDR_WIDTH-1:0]    bias_addr,
    output logic                     pe_enable,
    output logic                     layer,
    output logic [FC_WCOL_WIDTH-1:0] fc_wcol,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [ADDR_WIDTH-1:0]    LAST_ROW  = ADDR_WIDTH'(OUT_ROWS - 1);
    localparam logic [ADDR_WIDTH-1:0]    LAST_FILT = ADDR_WIDTH'(OUT_CH - 1);
    localparam logic [ADDR_WIDTH-1:0]    ADDR_ZERO = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0]    ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [FC_WCOL_WIDTH-1:0] LAST_COL  = FC_WCOL_WIDTH'(FC_COLS - 1);
    localparam logic [FC_WCOL_WIDTH-1:0] COL_ZERO  = FC_WCOL_WIDTH'(0);
    localparam logic [FC_WCOL_WIDTH-1:0] COL_ONE   = FC_WCOL_WIDTH'(1);
    localparam logic [LAT_W-1:0]         LAT_END   = LAT_W'(MEM_LAT - 1);
    localparam logic [LAT_W-1:0]         LAT_ZERO  = LAT_W'(0);
    localparam logic [LAT_W-1:0]         LAT_ONE   = LAT_W'(1);
    localparam logic [WD_W-1:0]          WD_END    = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0]          WD_ZERO   = WD_W'(0);
    localparam logic [WD_W-1:0]          WD_ONE    = WD_W'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_COMPUTE = 3'd2,
        S_ADVANCE = 3'd3,
        S_DONE    = 3'd4
    } state_e;

    state_e                   state_q;
    logic                     rd_en_q;
    logic                     pe_enable_q;
    logic                     layer_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     err_q;
    logic [ADDR_WIDTH-1:0]    data_addr_q;
    logic [ADDR_WIDTH-1:0]    weight_addr_q;
    logic [ADDR_WIDTH-1:0]    bias_addr_q;
    logic [FC_WCOL_WIDTH-1:0] fc_wcol_q;
    logic [LAT_W-1:0]         lat_q;
    logic [WD_W-1:0]          wd_q;

    logic flag_s;
    logic last_col_s;
    logic row_wrap_s;
    logic last_step_s;
    logic fc_early_s;

    // The address registers double as the loop counters: row in data_addr, filter/column in weight_addr.
    assign flag_s      = layer_q ? fc_line_done : conv_comp;
    assign last_col_s  = (fc_wcol_q == LAST_COL);
    assign row_wrap_s  = (data_addr_q == LAST_ROW);
    assign last_step_s = layer_q ? last_col_s : (row_wrap_s && (weight_addr_q == LAST_FILT));
    assign fc_early_s  = layer_q && fc_done && !last_col_s;

    // Layer sequencing FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            rd_en_q       <= 1'b0;
            pe_enable_q   <= 1'b0;
            layer_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            data_addr_q   <= ADDR_ZERO;
            weight_addr_q <= ADDR_ZERO;
            bias_addr_q   <= ADDR_ZERO;
            fc_wcol_q     <= COL_ZERO;
            lat_q         <= LAT_ZERO;
            wd_q          <= WD_ZERO;
        end else begin
            done_q <= 1'b0;
            if ((state_q != S_IDLE) && abort) begin
                state_q     <= S_IDLE;
                rd_en_q     <= 1'b0;
                pe_enable_q <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            state_q       <= S_FETCH;
                            layer_q       <= layer_sel;
                            err_q         <= 1'b0;
                            data_addr_q   <= ADDR_ZERO;
                            weight_addr_q <= ADDR_ZERO;
                            bias_addr_q   <= ADDR_ZERO;
                            fc_wcol_q     <= COL_ZERO;
                            lat_q         <= LAT_ZERO;
                            rd_en_q       <= 1'b1;
                            busy_q        <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                    S_FETCH: begin
                        if (fc_early_s) begin
                            state_q <= S_DONE;
                            err_q   <= 1'b1;
                            rd_en_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else if (lat_q == LAT_END) begin
                            state_q     <= S_COMPUTE;
                            rd_en_q     <= 1'b0;
                            pe_enable_q <= 1'b1;
                            wd_q        <= WD_ZERO;
                        end else begin
                            lat_q <= lat_q + LAT_ONE;
                        end
                    end
                    S_COMPUTE: begin
                        if (fc_early_s) begin
                            state_q     <= S_DONE;
                            err_q       <= 1'b1;
                            pe_enable_q <= 1'b0;
                            done_q      <= 1'b1;
                        end else if (flag_s) begin
                            // A flag on the final watchdog cycle still counts as a normal completion.
                            state_q     <= S_ADVANCE;
                            pe_enable_q <= 1'b0;
                            if (layer_q && last_col_s && !fc_done) begin
                                err_q <= 1'b1;
                            end else begin
                                err_q <= err_q;
                            end
                        end else if (wd_q == WD_END) begin
                            state_q     <= S_DONE;
                            err_q       <= 1'b1;
                            pe_enable_q <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            wd_q <= wd_q + WD_ONE;
                        end
                    end
                    S_ADVANCE: begin
                        if (fc_early_s) begin
                            state_q <= S_DONE;
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                        end else if (last_step_s) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_FETCH;
                            rd_en_q <= 1'b1;
                            lat_q   <= LAT_ZERO;
                            if (layer_q) begin
                                fc_wcol_q     <= fc_wcol_q + COL_ONE;
                                weight_addr_q <= weight_addr_q + ADDR_ONE;
                                bias_addr_q   <= bias_addr_q + ADDR_ONE;
                            end else if (row_wrap_s) begin
                                data_addr_q   <= ADDR_ZERO;
                                weight_addr_q <= weight_addr_q + ADDR_ONE;
                                bias_addr_q   <= bias_addr_q + ADDR_ONE;
                            end else begin
                                data_addr_q <= data_addr_q + ADDR_ONE;
                            end
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q     <= S_IDLE;
                        rd_en_q     <= 1'b0;
                        pe_enable_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rd_en       = rd_en_q;
    assign pe_enable   = pe_enable_q;
    assign layer       = layer_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign data_addr   = data_addr_q;
    assign weight_addr = weight_addr_q;
    assign bias_addr   = bias_addr_q;
    assign fc_wcol     = fc_wcol_q;

endmodule
